// File: rtl/noc_params.sv
// Shared NoC types: flit format, packet descriptor and node TX state encoding.
// A head flit carries {dest_x, dest_y, head payload}, which exactly fills the flit data field.
package noc_params;

    localparam int VC_NUM            = 2;
    localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DEST_ADDR_SIZE_X  = 2;
    localparam int DEST_ADDR_SIZE_Y  = 2;
    localparam int HEAD_PAYLOAD_SIZE = 12;
    localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [FLIT_DATA_SIZE-1:0]   data;
    } flit_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  dest_x;
        logic [DEST_ADDR_SIZE_Y-1:0]  dest_y;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } pkt_desc_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_ALLOC = 2'd1,
        TX_HEAD  = 2'd2,
        TX_BODY  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/node_packet_tx_vc_select.sv
// VC picker: eligible mask in, onehot/index of the chosen VC out, purely combinational.
// Lowest index wins; with NODE_TX_RR_VC_EN the search starts one past the last grant.
module vc_select
    import noc_params::*;
(
`ifdef NODE_TX_RR_VC_EN
    input  logic                clk,
    input  logic                rst,
    input  logic                grant,
`endif
    input  logic [VC_NUM-1:0]   eligible,
    output logic [VC_NUM-1:0]   onehot,
    output logic [VC_SIZE-1:0]  index,
    output logic                found
);

`ifdef NODE_TX_RR_VC_EN
    logic [VC_SIZE-1:0] ptr;
    int                 cand;

    // Walk downwards so the candidate closest to ptr is the one left standing.
    always_comb begin
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % VC_NUM;
            if (eligible[cand]) begin
                index = VC_SIZE'(cand);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant && found) begin
            ptr <= (index == VC_SIZE'(VC_NUM - 1)) ? '0 : index + 1'b1;
        end
    end
`else
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                index = VC_SIZE'(i);
                found = 1'b1;
            end
        end
    end
`endif

    assign onehot = found ? (VC_NUM'(1) << index) : '0;

endmodule

// File: rtl/node_packet_tx.sv
// Node injection engine: serialises a descriptor plus body words into head/body/tail flits on a free VC.
// Flits registered one cycle after decision (accept to valid = 3 cycles); stalls on VC off or empty body stream. Option: NODE_TX_RR_VC_EN.
module node_packet_tx
    import noc_params::*;
#(
    parameter int  MAX_PKT_LEN  = 8,
    parameter int  GUARD_CYCLES = 2,
    localparam int LEN_W        = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid_i,
    output logic                         pkt_ready_o,
    input  logic [LEN_W-1:0]             pkt_len_i,
    input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_dest_x_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_dest_y_i,
    input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
    input  logic                         pl_valid_i,
    output logic                         pl_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]    pl_data_i,
    output flit_t                        data_o,
    output logic                         is_valid_o,
    input  logic [VC_NUM-1:0]            is_on_off_i,
    input  logic [VC_NUM-1:0]            is_allocatable_i,
    output logic                         busy_o
);

    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

    tx_state_t            state, state_nxt;
    pkt_desc_t            desc;
    logic [LEN_W-1:0]     remaining;
    logic [VC_SIZE-1:0]   cur_vc;
    logic [VC_NUM-1:0]    cur_vc_oh, last_vc_oh;
    logic [GUARD_W-1:0]   guard_cnt;
    logic [VC_NUM-1:0]    guard_mask, eligible, sel_onehot;
    logic [VC_SIZE-1:0]   sel_index;
    logic                 sel_found, alloc_grant, vc_on, emit, is_last;
    flit_t                emit_flit;

    // The router's allocatable flag lags the tail by a few cycles; keep the last VC out meanwhile.
    assign guard_mask = (guard_cnt != '0) ? last_vc_oh : '0;
    assign eligible   = is_allocatable_i & ~guard_mask;
    assign vc_on      = |(is_on_off_i & cur_vc_oh);
    assign busy_o     = (state != TX_IDLE);

    vc_select u_vc_select (
`ifdef NODE_TX_RR_VC_EN
        .clk      (clk),
        .rst      (rst),
        .grant    (alloc_grant),
`endif
        .eligible (eligible),
        .onehot   (sel_onehot),
        .index    (sel_index),
        .found    (sel_found)
    );

    always_comb begin
        state_nxt        = state;
        pkt_ready_o      = 1'b0;
        pl_ready_o       = 1'b0;
        alloc_grant      = 1'b0;
        emit             = 1'b0;
        is_last          = 1'b0;
        emit_flit        = '0;
        emit_flit.vc_id  = cur_vc;
        case (state)
            TX_IDLE: begin
                pkt_ready_o = 1'b1;
                if (pkt_valid_i) state_nxt = TX_ALLOC;
            end
            TX_ALLOC: begin
                if (sel_found) begin
                    alloc_grant = 1'b1;
                    state_nxt   = TX_HEAD;
                end
            end
            TX_HEAD: begin
                if (vc_on) begin
                    emit                 = 1'b1;
                    is_last              = (remaining == '0);
                    emit_flit.flit_label = is_last ? HEADTAIL : HEAD;
                    emit_flit.data       = desc;
                    state_nxt            = is_last ? TX_IDLE : TX_BODY;
                end
            end
            TX_BODY: begin
                pl_ready_o = vc_on;
                if (pl_valid_i && vc_on) begin
                    emit                 = 1'b1;
                    is_last              = (remaining == LEN_W'(1));
                    emit_flit.flit_label = is_last ? TAIL : BODY;
                    emit_flit.data       = pl_data_i;
                    if (is_last) state_nxt = TX_IDLE;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= TX_IDLE;
            desc       <= '0;
            remaining  <= '0;
            cur_vc     <= '0;
            cur_vc_oh  <= '0;
            last_vc_oh <= '0;
            guard_cnt  <= '0;
            data_o     <= '0;
            is_valid_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            is_valid_o <= emit;
            if (emit) data_o <= emit_flit;

            // A zero length is treated as a single-flit packet.
            if (state == TX_IDLE && pkt_valid_i) begin
                desc      <= '{dest_x: pkt_dest_x_i, dest_y: pkt_dest_y_i, head_pl: pkt_head_pl_i};
                remaining <= (pkt_len_i == '0) ? '0 : pkt_len_i - 1'b1;
            end else if (emit && state == TX_BODY) begin
                remaining <= remaining - 1'b1;
            end

            if (alloc_grant) begin
                cur_vc    <= sel_index;
                cur_vc_oh <= sel_onehot;
            end

            if (emit && is_last) begin
                last_vc_oh <= cur_vc_oh;
                guard_cnt  <= GUARD_W'(GUARD_CYCLES);
            end else if (guard_cnt != '0) begin
                guard_cnt  <= guard_cnt - 1'b1;
            end
        end
    end

endmodule

// File: doc/node_packet_tx.md
Name: node_packet_tx

Overview:
- Node-side injection engine that drives the local input port of a router through the node link's upstream pins.
- Accepts one packet descriptor at a time and a stream of body payload words.
- Selects a free virtual channel (VC), serialises the packet into head/body/tail flits, and honours per-VC on/off flow control and VC allocatability.
- Transmitter counterpart of the node link: it produces data_i/is_valid_i and consumes is_on_off_o/is_allocatable_o.

Parameters:
- MAX_PKT_LEN, 8, maximum flits per packet (≥1); LEN_W = $clog2(MAX_PKT_LEN+1).
- GUARD_CYCLES, 2, cycles a just-used VC is excluded from selection after its tail flit (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (asserted when rst = 0)
- pkt_valid_i  in  1  packet descriptor valid
- pkt_ready_o  out  1  descriptor accepted when pkt_valid_i & pkt_ready_o
- pkt_len_i  in  LEN_W  flit count, 1..MAX_PKT_LEN
- pkt_dest_x_i  in  DEST_ADDR_SIZE_X  destination x
- pkt_dest_y_i  in  DEST_ADDR_SIZE_Y  destination y
- pkt_head_pl_i  in  HEAD_PAYLOAD_SIZE  head flit payload
- pl_valid_i  in  1  body payload word valid
- pl_ready_o  out  1  body word consumed when pl_valid_i & pl_ready_o
- pl_data_i  in  FLIT_DATA_SIZE  body/tail payload
- data_o  out  flit_t  flit to router local port
- is_valid_o  out  1  data_o valid
- is_on_off_i  in  VC_NUM  per-VC on (1) / off (0) from router
- is_allocatable_i  in  VC_NUM  per-VC free-for-new-packet from router
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, data_o = 0, is_valid_o = 0, guard counter 0, cur_vc 0, pl_ready_o = 0.
- FSM states: IDLE, ALLOC, HEAD, BODY.
- IDLE:
  - pkt_ready_o = 1.
  - On accept: latch len/dest/head_pl, set remaining = len-1, go to ALLOC.
  - len = 0 or len > MAX_PKT_LEN is illegal; the bench asserts on it; RTL clamps 0 to 1.
- ALLOC:
  - Eligible mask = is_allocatable_i & ~guard_mask.
  - If nonzero: cur_vc = lowest eligible index, go to HEAD.
  - Otherwise stay in ALLOC (no timeout).
- HEAD:
  - If is_on_off_i[cur_vc] = 1: register a flit with vc_id = cur_vc, dest, head_pl.
  - flit_label = HEADTAIL if len = 1, else HEAD.
  - Next state: IDLE if len = 1, else BODY.
  - If off: hold, emit nothing.
- BODY:
  - pl_ready_o = is_on_off_i[cur_vc] (combinational; 0 in all other states).
  - On pl_valid_i & pl_ready_o: register a flit with payload pl_data_i.
  - flit_label = TAIL if remaining = 1, else BODY; decrement remaining.
  - After the TAIL flit, go to IDLE.
- Output timing:
  - data_o/is_valid_o are registered; is_valid_o is high exactly the cycle after each emission decision, low otherwise.
  - data_o holds its last value when not valid.
- Latency: descriptor accepted at cycle t, VC available → HEAD decided t+2, is_valid_o high t+3. Back-to-back body flits are emitted every cycle while on and valid.
- Guard:
  - When a tail or headtail is emitted, record last_vc and load guard counter = GUARD_CYCLES.
  - The counter decrements each cycle down to 0.
  - guard_mask = onehot(last_vc) while counter != 0. This prevents reuse of a VC whose is_allocatable_i has not yet fallen.
- Flow control: on/off can change any cycle; the sampled value in the decision cycle governs. A flit is never emitted on a VC whose is_on_off_i is 0 in that cycle.
- Reset mid-packet: immediate return to IDLE, is_valid_o = 0, partial packet abandoned. No tail is sent; the router is reset together with this block.

Optional Feature:
- Macro NODE_TX_RR_VC_EN.
- Defined: ALLOC picks by round-robin, starting the search at (last granted VC + 1) mod VC_NUM; the pointer resets to 0.
- Undefined: fixed lowest-index priority as above.
- Guard behaviour is identical in both builds.

Decomposition:
- flit_t, flit_label_t, VC_NUM, FLIT_DATA_SIZE, HEAD_PAYLOAD_SIZE and DEST_ADDR_SIZE_X/Y come from noc_params.
- Add the packet descriptor struct (pkt_desc_t) and the tx state enum to noc_params.
- One sub-module: vc_select (eligible mask in → onehot and index out; round-robin pointer inside when NODE_TX_RR_VC_EN is defined).

Test Plan:
- VC_NUM=2, all allocatable/on; len=1, dest (2,3) → single HEADTAIL on vc 0, is_valid_o high at t+3, busy_o low after.
- len=4, payload words 0xA,0xB,0xC always valid → HEAD, BODY(0xA), BODY(0xB), TAIL(0xC) on consecutive cycles, same vc_id.
- len=3; is_on_off_i[0] low for 5 cycles mid-body → no valid flits and pl_ready_o = 0 for those 5 cycles; resumes with the correct next payload, no duplicates.
- is_allocatable_i = 2'b00 for 10 cycles → stays in ALLOC, no output; then 2'b10 → head on vc 1.
- Two len=1 packets back-to-back, is_allocatable_i stuck 2'b11 → second uses vc 1 (guard); with NODE_TX_RR_VC_EN, third uses vc 0.
- Assert rst=0 mid-BODY → is_valid_o drops asynchronously; after release, pkt_ready_o = 1 and a new len=2 packet is sent correctly.
